// File: rtl/riscv_multicycle_core_if.sv
// Instruction fetch channel: valid/ready request, valid-only response.
interface riscv_multicycle_core_if #(
    parameter int unsigned XLEN = 32
);
    logic            insn_req_valid;
    logic            insn_req_ready;
    logic [XLEN-1:0] insn_addr;
    logic            insn_rsp_valid;
    logic [31:0]     insn_rsp_data;

    modport master (
        output insn_req_valid,
        output insn_addr,
        input  insn_req_ready,
        input  insn_rsp_valid,
        input  insn_rsp_data
    );

    modport slave (
        input  insn_req_valid,
        input  insn_addr,
        output insn_req_ready,
        output insn_rsp_valid,
        output insn_rsp_data
    );
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E integer core: fetch, wait for response, execute.
// Illegal instructions halt the core until reset.
module riscv_multicycle_core #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    riscv_multicycle_core_if.master insn,
    output logic                   retire,
    output logic [XLEN-1:0]        retire_pc,
    output logic                   illegal,
    input  logic [4:0]             dbg_reg_addr,
    output logic [XLEN-1:0]        dbg_reg_data
);

    localparam int unsigned IDXW = $clog2(NUM_REGS);
    localparam int unsigned SHW  = $clog2(XLEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic            req_valid;
    logic [XLEN-1:0] regs [NUM_REGS];

    function automatic logic reg_ok(input logic [4:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    // Instruction fields and sign-extended immediates
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign imm_i  = XLEN'($signed(ir[31:20]));
    assign imm_u  = XLEN'($signed({ir[31:12], 12'b0}));
    assign imm_b  = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_j  = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

    // Out-of-range indices read as zero; legality check catches them separately
    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0 || !reg_ok(rs1)) ? '0 : regs[rs1[IDXW-1:0]];
    assign rs2_val = (rs2 == 5'd0 || !reg_ok(rs2)) ? '0 : regs[rs2[IDXW-1:0]];
    assign dbg_reg_data = (dbg_reg_addr == 5'd0 || !reg_ok(dbg_reg_addr)) ?
                          '0 : regs[dbg_reg_addr[IDXW-1:0]];

    logic [XLEN-1:0] op_b, alu;
    logic [SHW-1:0]  shamt;
    logic            alt;

    assign op_b  = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt = op_b[SHW-1:0];
    assign alt   = ir[30];

    always_comb begin
        alu = '0;
        case (f3)
            3'd0: alu = (opcode == OPC_OP && alt) ? rs1_val - op_b : rs1_val + op_b;
            3'd1: alu = rs1_val << shamt;
            3'd2: alu = XLEN'($signed(rs1_val) < $signed(op_b));
            3'd3: alu = XLEN'(rs1_val < op_b);
            3'd4: alu = rs1_val ^ op_b;
            3'd5: alu = alt ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6: alu = rs1_val | op_b;
            default: alu = rs1_val & op_b;
        endcase
    end

    logic taken;
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'd0: taken = (rs1_val == rs2_val);
            3'd1: taken = (rs1_val != rs2_val);
            3'd4: taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5: taken = !($signed(rs1_val) < $signed(rs2_val));
            3'd6: taken = (rs1_val < rs2_val);
            3'd7: taken = !(rs1_val < rs2_val);
            default: taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] pc_plus4, br_target, jal_target;
    assign pc_plus4   = pc + XLEN'(4);
    assign br_target  = pc + imm_b;
    assign jal_target = pc + imm_j;

    // Shift-immediates on RV32 must keep bit 25 clear
    logic shift_ok;
    always_comb begin
        shift_ok = 1'b1;
        if (f3 == 3'd1)
            shift_ok = (ir[31:26] == 6'd0) && (XLEN > 32 || !ir[25]);
        else if (f3 == 3'd5)
            shift_ok = (ir[31:26] == 6'd0 || ir[31:26] == 6'b010000) && (XLEN > 32 || !ir[25]);
    end

    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_OP:     legal = (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))
                                && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
            OPC_IMM:    legal = shift_ok && reg_ok(rd) && reg_ok(rs1);
            OPC_LUI,
            OPC_AUIPC:  legal = reg_ok(rd);
            OPC_JAL:    legal = reg_ok(rd) && (jal_target[1:0] == 2'b00);
            OPC_BRANCH: legal = (f3 != 3'd2) && (f3 != 3'd3) && reg_ok(rs1) && reg_ok(rs2)
                                && !(taken && br_target[1:0] != 2'b00);
            default:    legal = 1'b0;
        endcase
    end

    logic [XLEN-1:0] wb_data, next_pc;
    logic            wb_en;
    always_comb begin
        wb_data = '0;
        wb_en   = 1'b0;
        next_pc = pc_plus4;
        case (opcode)
            OPC_OP, OPC_IMM: begin wb_data = alu;        wb_en = 1'b1; end
            OPC_LUI:         begin wb_data = imm_u;      wb_en = 1'b1; end
            OPC_AUIPC:       begin wb_data = pc + imm_u; wb_en = 1'b1; end
            OPC_JAL: begin
                wb_data = pc_plus4;
                wb_en   = 1'b1;
                next_pc = jal_target;
            end
            OPC_BRANCH: if (taken) next_pc = br_target;
            default: ;
        endcase
    end

    logic rf_we;
    assign rf_we = (state == EXEC) && legal && wb_en && (rd != 5'd0);

    always_ff @(posedge clock) begin
        if (rf_we) regs[rd[IDXW-1:0]] <= wb_data;
    end

    // Instruction sequencer with registered handshake and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            req_valid <= 1'b1;
            retire    <= 1'b0;
            retire_pc <= '0;
            illegal   <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: if (insn.insn_req_ready) begin
                    req_valid <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (insn.insn_rsp_valid) begin
                    ir    <= insn.insn_rsp_data;
                    state <= EXEC;
                end
                EXEC: if (!legal) begin
                    illegal <= 1'b1;
                    state   <= HALT;
                end else begin
                    pc        <= next_pc;
                    retire    <= 1'b1;
                    retire_pc <= pc;
                    req_valid <= 1'b1;
                    state     <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    assign insn.insn_req_valid = req_valid;
    assign insn.insn_addr      = pc;

endmodule

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Parametrised multi-cycle RV32I/RV32E integer core. It has its own register file, ALU, immediate decode and branch unit. A state machine sequences each instruction through fetch, response wait and execute. Instruction memory is reached through a valid/ready request channel and a valid-only response channel, so memories with arbitrary latency are supported. This is the next-generation core top: it adds control flow, handshaked fetch, illegal-instruction trapping and a debug read port.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- NUM_REGS, 32: architectural registers; 32 (RV32I) or 16 (RV32E).
- RESET_PC, 0: fetch address after reset; must be 4-byte aligned.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset; asynchronous and active-low (0 = reset asserted).
- insn_req_valid  out  1  fetch request valid.
- insn_req_ready  in  1  memory accepts the request.
- insn_addr  out  XLEN  fetch address; equals pc.
- insn_rsp_valid  in  1  instruction word valid.
- insn_rsp_data  in  32  instruction word.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_pc  out  XLEN  pc of the retiring instruction; valid when retire=1.
- illegal  out  1  sticky; core halted on an illegal instruction.
- dbg_reg_addr  in  5  register index for debug read.
- dbg_reg_data  out  XLEN  combinational read of dbg_reg_addr; reads 0 for x0 and for indices >= NUM_REGS.

## Operation
- States: FETCH, WAIT, EXEC, HALT.
- FETCH: insn_req_valid=1 and insn_addr=pc. When insn_req_ready=1, go to WAIT. Any insn_rsp_valid seen in FETCH is ignored.
- WAIT: when insn_rsp_valid=1, capture insn_rsp_data into the instruction register and go to EXEC. Otherwise stay in WAIT.
- EXEC: decode, execute, write back, update pc, pulse retire, then go to FETCH. If the instruction is illegal, go to HALT instead: no writeback, no retire, pc unchanged, illegal set.
- HALT: absorbing state. Only reset leaves it. insn_req_valid=0.
- Supported instructions:
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI, AUIPC, JAL.
  - BRANCH: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Everything else is illegal. This includes loads, stores, JALR, SYSTEM, FENCE, W-ops and funct7 values not listed for a given funct3.
- Further illegal conditions:
  - any rd/rs1/rs2 index >= NUM_REGS;
  - shift-immediate bit 25 set when XLEN=32;
  - a jump or taken-branch target with bits [1:0] != 0.
- Arithmetic:
  - All immediates are sign-extended to XLEN.
  - Add/sub wrap modulo 2^XLEN.
  - Shift amount is the low log2(XLEN) bits of rs2 or the immediate.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; results are 0 or 1, zero-extended.
- Control flow:
  - JAL writes pc+4 to rd and sets pc = pc + imm_j.
  - A taken branch sets pc = pc + imm_b.
  - All other instructions set pc = pc+4, wrapping modulo 2^XLEN.
- x0 always reads 0. Writes to x0 are discarded.
- Register file: two combinational read ports plus the debug port, one synchronous write port. There is no reset of register contents; the verification bench must not read a register before writing it.

## Timing
- Reset (reset=0) asynchronously forces:
  - state=FETCH, pc=RESET_PC;
  - insn_req_valid=1 (as soon as reset is released; it reflects FETCH);
  - retire=0, retire_pc=0, illegal=0, instruction register=0.
- Reset mid-WAIT or mid-EXEC abandons the instruction: no writeback, no retire. A late insn_rsp_valid after reset is ignored because the core is then in FETCH.
- Minimum latency is 3 cycles per instruction: FETCH accept, WAIT with same-cycle-next response, EXEC. Peak throughput is one retire every 3 cycles.
- Each cycle insn_req_ready=0 in FETCH adds one cycle. Each cycle insn_rsp_valid=0 in WAIT adds one cycle.
- insn_addr is stable while insn_req_valid=1 and unaccepted.
- At most one request is outstanding. The memory must not return a response in the same cycle it accepts the request.
- retire and retire_pc are registered and assert in the cycle after EXEC. A register written in EXEC is visible on dbg_reg_data from that same cycle.
- illegal rises in the cycle after EXEC detects the fault and stays high until reset.

## Test plan
- ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2, with zero-latency memory -> retires at 3-cycle spacing; x1=5, x2=0xFFFFFFFE, x3=7.
- BEQ x0,x0,+8 at pc 0x10 -> next insn_addr=0x18; BNE x0,x0,+8 at 0x18 -> next insn_addr=0x1C; BLTU 1 vs 0xFFFFFFFF -> taken.
- JAL x5,-16 at pc 0x40 -> x5=0x44, next insn_addr=0x30. ADDI x0,x0,9 -> x0 reads 0.
- insn_req_ready held 0 for 4 cycles, then insn_rsp_valid delayed 3 cycles -> insn_addr stable throughout, exactly one retire, total latency 10 cycles.
- Opcode 0x0000007F, and separately ADD x17 with NUM_REGS=16 -> illegal=1, insn_req_valid=0, no retire, destination register unchanged; reset=0 clears illegal and restarts fetch at RESET_PC.
- Assert reset during WAIT, then drive insn_rsp_valid=1 on release -> response ignored, insn_addr=RESET_PC, no retire until the next full fetch.
